sgd_model_writeback_engine: RTL and testbench

SGD_MODEL_WRITEBACK_ENGINE -- requirements
Module: sgd_model_writeback_engine

---
 rtl/sgd_model_writeback_engine.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_sgd_model_writeback_engine.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sgd_model_writeback_engine.sv
// sgd_model_writeback_engine
// Streams a trained model out of NUM_ENGINES parallel model banks to host
// memory. The engine issues write commands (cmd_*) that cover the whole model
// in bursts of at most MAX_BURST_BYTES. Independently, it reads model rows
// from memory and emits them as OUT_WIDTH-bit beats (data_*). Beats go out
// engine 0..NUM_ENGINES-1 and, within an engine, from the low slice upwards.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   start               one-cycle pulse; samples base_addr and dimension
//   base_addr           host byte address of the model
//   dimension           number of 32-bit features
//   mem_rd_addr/data    model row read port, MEM_RD_LATENCY cycles latency
//   cmd_valid/ready     write command handshake; cmd_addr, cmd_len (bytes)
//   data_valid/ready    write data handshake; data_out
//   busy, done          activity flag, one-cycle completion pulse
//   err_zero_dim        last accepted start had dimension == 0
//   status_beats        accepted beat count (only with SGD_WB_STATUS_COUNTER_EN)
//
// Optional feature macro: SGD_WB_STATUS_COUNTER_EN enables the saturating
// beat counter on status_beats. When the macro is not defined, status_beats
// is tied to 0.
module sgd_model_writeback_engine #(
  parameter int NUM_ENGINES     = 8,
  parameter int BANK_WIDTH      = 2048,
  parameter int OUT_WIDTH       = 512,
  parameter int MEM_ADDR_WIDTH  = 8,
  parameter int MEM_RD_LATENCY  = 2,
  parameter int MAX_BURST_BYTES = 4096
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic [63:0]                       base_addr,
  input  logic [31:0]                       dimension,
  output logic [MEM_ADDR_WIDTH-1:0]         mem_rd_addr,
  input  logic [NUM_ENGINES*BANK_WIDTH-1:0] mem_rd_data,
  output logic                              cmd_valid,
  input  logic                              cmd_ready,
  output logic [63:0]                       cmd_addr,
  output logic [31:0]                       cmd_len,
  output logic [OUT_WIDTH-1:0]              data_out,
  output logic                              data_valid,
  input  logic                              data_ready,
  output logic                              busy,
  output logic                              done,
  output logic                              err_zero_dim,
  output logic [31:0]                       status_beats
);

  localparam int ROW_W = NUM_ENGINES * BANK_WIDTH;
  localparam int BPB   = BANK_WIDTH / OUT_WIDTH;
  localparam int BPR   = NUM_ENGINES * BPB;            // beats per row
  localparam int BI_W  = (BPR > 1) ? $clog2(BPR) : 1;
  localparam logic [31:0]     FPR_C     = 32'(ROW_W / 32);
  localparam logic [31:0]     RB_C      = 32'(ROW_W / 8);
  localparam logic [31:0]     MAXB_C    = 32'(MAX_BURST_BYTES);
  localparam logic [BI_W-1:0] BEAT_LAST = BI_W'(BPR - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_RUN    = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  state_t                     state_r;
  logic [63:0]                base_r;
  logic [31:0]                dim_r;
  logic [31:0]                rows_r;
  logic [31:0]                total_r;
  logic [31:0]                off_r;
  logic                       cmd_done_r;
  logic                       data_done_r;
  logic [31:0]                fetch_row_r;
  logic                       fetch_first_r;
  logic [MEM_RD_LATENCY:0]    rd_pipe_r;
  logic [ROW_W-1:0]           stage_r;
  logic                       stage_full_r;
  logic [ROW_W-1:0]           cur_r;
  logic [BI_W-1:0]            beat_idx_r;
  logic [31:0]                rows_out_r;
  logic [MEM_ADDR_WIDTH-1:0]  mem_rd_addr_r;
  logic                       cmd_valid_r;
  logic [63:0]                cmd_addr_r;
  logic [31:0]                cmd_len_r;
  logic [OUT_WIDTH-1:0]       data_out_r;
  logic                       data_valid_r;
  logic                       busy_r;
  logic                       done_r;
  logic                       err_r;

  logic        cmd_hs_s, data_hs_s, row_last_s, cmd_last_hs_s, data_last_hs_s;
  logic        rd_issue_s, move_s;
  logic [31:0] cmd_next_off_s, rows_calc_s;

  // Burst length for the bytes still to be commanded
  function automatic logic [31:0] burst_len(input logic [31:0] rem);
    if (rem < MAXB_C) begin
      return rem;
    end else begin
      return MAXB_C;
    end
  endfunction

  assign cmd_hs_s       = cmd_valid_r & cmd_ready;
  assign data_hs_s      = data_valid_r & data_ready;
  assign row_last_s     = (beat_idx_r == BEAT_LAST);
  assign cmd_next_off_s = off_r + cmd_len_r;
  assign cmd_last_hs_s  = cmd_hs_s && (cmd_next_off_s == total_r);
  assign data_last_hs_s = data_hs_s && row_last_s && (rows_out_r == rows_r);
  assign rows_calc_s    = (dim_r / FPR_C) + {31'd0, ((dim_r % FPR_C) != 32'd0)};
  // The next row is read on the first-beat handshake of the current row.
  // The staging register has been emptied by then, and the row arrives well
  // before the current row drains.
  assign rd_issue_s     = (state_r == ST_RUN) && (fetch_row_r < rows_r) &&
                          (fetch_first_r || (data_hs_s && (beat_idx_r == BI_W'(0))));
  // Staging moves to the output buffer when the output side is empty or
  // when its last beat is accepted in this cycle. This keeps the beats
  // back-to-back.
  assign move_s         = stage_full_r && (!data_valid_r || (data_hs_s && row_last_s));

  // Control FSM with command path, row fetch and beat output
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_IDLE;
      base_r        <= 64'd0;
      dim_r         <= 32'd0;
      rows_r        <= 32'd0;
      total_r       <= 32'd0;
      off_r         <= 32'd0;
      cmd_done_r    <= 1'b0;
      data_done_r   <= 1'b0;
      fetch_row_r   <= 32'd0;
      fetch_first_r <= 1'b0;
      rd_pipe_r     <= '0;
      stage_r       <= '0;
      stage_full_r  <= 1'b0;
      cur_r         <= '0;
      beat_idx_r    <= '0;
      rows_out_r    <= 32'd0;
      mem_rd_addr_r <= '0;
      cmd_valid_r   <= 1'b0;
      cmd_addr_r    <= 64'd0;
      cmd_len_r     <= 32'd0;
      data_out_r    <= '0;
      data_valid_r  <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      rd_pipe_r <= {rd_pipe_r[MEM_RD_LATENCY-1:0], rd_issue_s};
      case (state_r)
        ST_IDLE: begin
          done_r        <= 1'b0;
          busy_r        <= 1'b0;
          mem_rd_addr_r <= '0;
          if (start) begin
            base_r <= base_addr;
            dim_r  <= dimension;
            busy_r <= 1'b1;
            if (dimension == 32'd0) begin
              err_r   <= 1'b1;
              done_r  <= 1'b1;
              state_r <= ST_FINISH;
            end else begin
              err_r   <= 1'b0;
              state_r <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          rows_r        <= rows_calc_s;
          total_r       <= rows_calc_s * RB_C;
          off_r         <= 32'd0;
          cmd_done_r    <= 1'b0;
          data_done_r   <= 1'b0;
          fetch_row_r   <= 32'd0;
          fetch_first_r <= 1'b1;
          stage_full_r  <= 1'b0;
          rows_out_r    <= 32'd0;
          beat_idx_r    <= '0;
          state_r       <= ST_RUN;
        end
        ST_RUN: begin
          if (rd_issue_s) begin
            mem_rd_addr_r <= fetch_row_r[MEM_ADDR_WIDTH-1:0];
            fetch_row_r   <= fetch_row_r + 32'd1;
            fetch_first_r <= 1'b0;
          end
          if (rd_pipe_r[MEM_RD_LATENCY]) begin
            stage_r      <= mem_rd_data;
            stage_full_r <= 1'b1;
          end else if (move_s) begin
            stage_full_r <= 1'b0;
          end
          if (move_s) begin
            cur_r        <= stage_r;
            data_out_r   <= stage_r[OUT_WIDTH-1:0];
            data_valid_r <= 1'b1;
            beat_idx_r   <= '0;
            rows_out_r   <= rows_out_r + 32'd1;
          end else if (data_hs_s) begin
            if (row_last_s) begin
              data_valid_r <= 1'b0;
            end else begin
              beat_idx_r <= beat_idx_r + BI_W'(1);
              data_out_r <= cur_r[(32'(beat_idx_r) + 32'd1) * 32'(OUT_WIDTH) +: OUT_WIDTH];
            end
          end
          if (data_last_hs_s) begin
            data_done_r <= 1'b1;
          end
          if (cmd_hs_s) begin
            off_r <= cmd_next_off_s;
            if (cmd_last_hs_s) begin
              cmd_valid_r <= 1'b0;
              cmd_done_r  <= 1'b1;
            end else begin
              cmd_addr_r <= base_r + {32'd0, cmd_next_off_s};
              cmd_len_r  <= burst_len(total_r - cmd_next_off_s);
            end
          end else if (!cmd_valid_r && !cmd_done_r) begin
            if (total_r == off_r) begin
              cmd_done_r <= 1'b1;
            end else begin
              cmd_valid_r <= 1'b1;
              cmd_addr_r  <= base_r + {32'd0, off_r};
              cmd_len_r   <= burst_len(total_r - off_r);
            end
          end
          if ((cmd_done_r || cmd_last_hs_s) && (data_done_r || data_last_hs_s)) begin
            done_r  <= 1'b1;
            state_r <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          done_r        <= 1'b0;
          busy_r        <= 1'b0;
          mem_rd_addr_r <= '0;
          state_r       <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef SGD_WB_STATUS_COUNTER_EN
  logic [31:0] status_beats_r;

  // Saturating count of accepted beats, cleared by an accepted start
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      status_beats_r <= 32'd0;
    end else if ((state_r == ST_IDLE) && start) begin
      status_beats_r <= 32'd0;
    end else if (data_hs_s && (status_beats_r != 32'hFFFF_FFFF)) begin
      status_beats_r <= status_beats_r + 32'd1;
    end else begin
      status_beats_r <= status_beats_r;
    end
  end

  assign status_beats = status_beats_r;
`else
  assign status_beats = 32'd0;
`endif

  assign mem_rd_addr  = mem_rd_addr_r;
  assign cmd_valid    = cmd_valid_r;
  assign cmd_addr     = cmd_addr_r;
  assign cmd_len      = cmd_len_r;
  assign data_out     = data_out_r;
  assign data_valid   = data_valid_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign err_zero_dim = err_r;

endmodule

// File: tb/tb_sgd_model_writeback_engine.sv
// Testbench for sgd_model_writeback_engine with default parameters.
// A behavioural memory produces pseudo-random rows. Each operation pushes
// the expected commands and beats into queues. A negedge monitor pops and
// compares them on every handshake and also checks that stalled outputs
// hold steady.
module tb_sgd_model_writeback_engine;
  localparam int NE    = 8;
  localparam int BW    = 2048;
  localparam int OW    = 512;
  localparam int AW    = 8;
  localparam int LAT   = 2;
  localparam int MAXB  = 4096;
  localparam int ROW_W = NE * BW;
  localparam int FPR   = ROW_W / 32;
  localparam int BPR   = ROW_W / OW;
  localparam int RB    = ROW_W / 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, start, cmd_valid, cmd_ready, data_valid, data_ready;
  logic             busy, done, err_zero_dim;
  logic [63:0]      base_addr, cmd_addr;
  logic [31:0]      dimension, cmd_len, status_beats;
  logic [AW-1:0]    mem_rd_addr;
  logic [ROW_W-1:0] mem_rd_data;
  logic [OW-1:0]    data_out;

  sgd_model_writeback_engine #(
    .NUM_ENGINES(NE), .BANK_WIDTH(BW), .OUT_WIDTH(OW), .MEM_ADDR_WIDTH(AW),
    .MEM_RD_LATENCY(LAT), .MAX_BURST_BYTES(MAXB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .dimension(dimension), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .data_out(data_out), .data_valid(data_valid),
    .data_ready(data_ready), .busy(busy), .done(done),
    .err_zero_dim(err_zero_dim), .status_beats(status_beats)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] mem_seed = 32'h1234_5678;

  logic [95:0] exp_cmd_q[$];
  logic [OW-1:0] exp_beat_q[$];
  int done_cnt, ncmd, nbeats, exp_nbeats, cmd_vcyc, data_vcyc, bubbles, max_addr;
  bit first_beat, nobubble;
  int cmd_stall = 0;
  bit data_rand = 1'b0;

  // Model content: every 32-bit word depends on row, word index and seed
  function automatic logic [ROW_W-1:0] gen_row(input logic [31:0] r);
    logic [ROW_W-1:0] v;
    for (int w = 0; w < ROW_W / 32; w++)
      v[w*32 +: 32] = (r * 32'h9E37_79B1) ^ (32'(w) * 32'h85EB_CA6B) ^ mem_seed ^ {r[15:0], 16'h5A5A};
    return v;
  endfunction

  // Memory with LAT = 2: address captured, then data registered
  logic [AW-1:0] a1 = '0;
  always @(posedge clk) begin
    a1 <= mem_rd_addr;
    mem_rd_data <= gen_row(32'(a1));
  end

  task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Sink/command ready drivers
  initial begin
    cmd_ready = 1'b1;
    data_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (cmd_stall > 0) begin
        cmd_ready = 1'b0;
        cmd_stall--;
      end else begin
        cmd_ready = 1'b1;
      end
      data_ready = data_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: scoreboard pops, stall stability, activity statistics
  bit cmd_hold = 0, data_hold = 0;
  logic [63:0] held_addr;
  logic [31:0] held_len;
  logic [OW-1:0] held_data;
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (!rst_n) begin
      cmd_hold = 0;
      data_hold = 0;
    end else begin
      if (32'(mem_rd_addr) > max_addr) max_addr = 32'(mem_rd_addr);
      if (cmd_valid) cmd_vcyc++;
      if (data_valid) data_vcyc++;
      if (cmd_hold) begin
        chk("cmd_valid_hold", OW'(cmd_valid), OW'(1));
        chk("cmd_addr_hold", OW'(cmd_addr), OW'(held_addr));
        chk("cmd_len_hold", OW'(cmd_len), OW'(held_len));
      end
      if (data_hold) begin
        chk("data_valid_hold", OW'(data_valid), OW'(1));
        chk("data_out_hold", data_out, held_data);
      end
      cmd_hold = cmd_valid && !cmd_ready;
      held_addr = cmd_addr;
      held_len = cmd_len;
      data_hold = data_valid && !data_ready;
      held_data = data_out;
      if (cmd_valid && cmd_ready) begin
        if (exp_cmd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cmd_unexpected actual=%0h/%0d required=none", cmd_addr, cmd_len);
        end else begin
          logic [95:0] e;
          e = exp_cmd_q.pop_front();
          chk("cmd_addr", OW'(cmd_addr), OW'(e[95:32]));
          chk("cmd_len", OW'(cmd_len), OW'(e[31:0]));
        end
        ncmd++;
      end
      if (data_valid && data_ready) begin
        if (exp_beat_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL beat_unexpected actual=%0h required=none", data_out);
        end else begin
          chk("beat_data", data_out, exp_beat_q.pop_front());
        end
        nbeats++;
        first_beat = 1;
      end else if (nobubble && first_beat && nbeats < exp_nbeats && !data_valid) begin
        bubbles++;
      end
    end
  end

  // Reference model: commands and beats derived from dimension and base
  task automatic build_expect(input logic [63:0] base, input logic [31:0] dim, input bit rnd);
    int rows, total, off, len;
    logic [ROW_W-1:0] row;
    mem_seed = $urandom;
    exp_cmd_q.delete();
    exp_beat_q.delete();
    rows = (int'(dim) + FPR - 1) / FPR;
    total = rows * RB;
    off = 0;
    while (off < total) begin
      len = (total - off > MAXB) ? MAXB : total - off;
      exp_cmd_q.push_back({base + 64'(off), 32'(len)});
      off += len;
    end
    for (int r = 0; r < rows; r++) begin
      row = gen_row(32'(r));
      for (int k = 0; k < BPR; k++) exp_beat_q.push_back(row[k*OW +: OW]);
    end
    exp_nbeats = rows * BPR;
    done_cnt = 0; ncmd = 0; nbeats = 0; cmd_vcyc = 0; data_vcyc = 0;
    bubbles = 0; max_addr = 0; first_beat = 0;
    nobubble = !rnd;
    data_rand = rnd;
    cmd_stall = rnd ? 50 : 0;
  endtask

  task automatic pulse_start(input logic [63:0] base, input logic [31:0] dim);
    @(posedge clk);
    #1;
    start = 1'b1; base_addr = base; dimension = dim;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_op(input logic [63:0] base, input logic [31:0] dim, input bit rnd);
    int waited, nexp_cmd, rows;
    bit got;
    build_expect(base, dim, rnd);
    nexp_cmd = exp_cmd_q.size();
    rows = (int'(dim) + FPR - 1) / FPR;
    pulse_start(base, dim);
    if (rnd) begin
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1; base_addr = 64'd0; dimension = 32'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    waited = 0;
    got = 0;
    while (!got && waited < 20000) begin
      @(negedge clk);
      waited++;
      if (done) got = 1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL done_timeout actual=none required=done dim=%0d", dim);
    end else begin
      if (dim == 32'd0) chk("zero_dim_done_latency", OW'(waited <= 2), OW'(1));
      chk("err_zero_dim", OW'(err_zero_dim), OW'(dim == 32'd0));
      chk("busy_at_done", OW'(busy), OW'(1));
      chk("cmds_left_at_done", OW'(exp_cmd_q.size()), OW'(0));
      chk("beats_left_at_done", OW'(exp_beat_q.size()), OW'(0));
`ifdef SGD_WB_STATUS_COUNTER_EN
      chk("status_beats", OW'(status_beats), OW'(exp_nbeats));
`else
      chk("status_beats_zero", OW'(status_beats), OW'(0));
`endif
    end
    repeat (2) @(negedge clk);
    chk("done_pulses", OW'(done_cnt), OW'(1));
    chk("busy_after", OW'(busy), OW'(0));
    chk("cmd_count", OW'(ncmd), OW'(nexp_cmd));
    chk("beat_count", OW'(nbeats), OW'(exp_nbeats));
    chk("rd_addr_idle", OW'(mem_rd_addr), OW'(0));
    if (dim != 32'd0) begin
      chk("max_rd_addr", OW'(max_addr), OW'(rows - 1));
    end else begin
      chk("zero_dim_valids", OW'(cmd_vcyc + data_vcyc), OW'(0));
    end
    if (!rnd) chk("bubbles", OW'(bubbles), OW'(0));
    data_rand = 1'b0;
    cmd_stall = 0;
  endtask

  task automatic reset_mid_op();
    int w;
    build_expect({$urandom, $urandom}, 32'd1024, 1'b0);
    pulse_start(exp_cmd_q[0][95:32], 32'd1024);
    w = 0;
    while (nbeats < 20 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    chk("reached_beat20", OW'(nbeats >= 20), OW'(1));
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_cmd_valid", OW'(cmd_valid), OW'(0));
    chk("rst_data_valid", OW'(data_valid), OW'(0));
    chk("rst_busy", OW'(busy), OW'(0));
    chk("rst_rd_addr", OW'(mem_rd_addr), OW'(0));
    repeat (2) @(negedge clk);
    chk("rst_no_done", OW'(done_cnt), OW'(0));
    rst_n = 1'b1;
    exp_cmd_q.delete();
    exp_beat_q.delete();
    run_op({$urandom, $urandom}, 32'd1024, 1'b0);
  endtask

  // Global watchdog
  initial begin
    #600000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = 64'd0;
    dimension = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_cmd_valid", OW'(cmd_valid), OW'(0));
    chk("reset_data_valid", OW'(data_valid), OW'(0));
    chk("reset_done", OW'(done), OW'(0));
    chk("reset_busy", OW'(busy), OW'(0));
    chk("reset_err", OW'(err_zero_dim), OW'(0));
    chk("reset_rd_addr", OW'(mem_rd_addr), OW'(0));
    chk("reset_cmd_addr", OW'(cmd_addr), OW'(0));
    chk("reset_cmd_len", OW'(cmd_len), OW'(0));
    chk("reset_data_out", data_out, OW'(0));
    chk("reset_status", OW'(status_beats), OW'(0));
    rst_n = 1'b1;
    run_op(64'h1000, 32'd1024, 1'b0);
    run_op(64'h20_0000, 32'd1500, 1'b0);
    run_op(64'h3000, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++)
      run_op({$urandom, $urandom}, 32'($urandom_range(1, 3000)), 1'b1);
    reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
